// File: rtl/config_stream_loader_if.sv
// Bundle of the loader's host-side stream, chain-side shift port and readback stream.
// master is the loader itself; slave is whatever feeds it words and owns the chain.
interface config_stream_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              cfg_reset;
    logic              cfg_shift;
    logic              cfg_in;
    logic              cfg_out;
    logic              rb_valid;
    logic [WORD_W-1:0] rb_data;

    modport master (
        input  start, word_valid, word_data, cfg_out,
        output busy, done, word_ready, cfg_reset, cfg_shift, cfg_in, rb_valid, rb_data
    );

    modport slave (
        output start, word_valid, word_data, cfg_out,
        input  busy, done, word_ready, cfg_reset, cfg_shift, cfg_in, rb_valid, rb_data
    );
endinterface

// File: rtl/config_stream_loader.sv
// Transmitter end of the PE configuration chain: clears the chain, shifts CHAIN_LEN bits
// in LSB-first from a word stream, and returns the bits falling out of the tail as words.
module config_stream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CLR_CYC   = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    config_stream_loader_if.master  bus
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CLR_W = $clog2(CLR_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLR_CYC - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    state_t            state, state_next;
    logic [CLR_W-1:0]  clr_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word_buf;
    logic [IDX_W-1:0]  idx;
    logic              full;
    logic [WORD_W-1:0] rb_buf;
    logic [IDX_W-1:0]  rb_idx;
    logic [WORD_W-1:0] rb_fill;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    logic busy, done, word_ready, cfg_reset, cfg_shift, cfg_in;
    logic last_word_bit, last_chain_bit, accept;

    assign last_word_bit  = (idx == LAST_IDX);
    assign last_chain_bit = (bit_cnt == LAST_BIT);
    assign accept         = bus.word_valid && word_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All handshake and chain outputs decode registered state only, so the word
    // inputs never reach cfg_shift/cfg_in combinationally.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        word_ready = 1'b0;
        cfg_reset  = 1'b0;
        cfg_shift  = 1'b0;
        cfg_in     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                cfg_reset = 1'b1;
                if (clr_cnt == LAST_CLR) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                cfg_shift = full;
                cfg_in    = full & word_buf[idx];
                // Refill on the last buffered bit for back-to-back words, unless that bit ends the chain.
                word_ready = !full || (last_word_bit && !last_chain_bit);
                if (full && last_chain_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rb_fill         = rb_buf;
        rb_fill[rb_idx] = bus.cfg_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt  <= '0;
            bit_cnt  <= '0;
            word_buf <= '0;
            idx      <= '0;
            full     <= 1'b0;
            rb_buf   <= '0;
            rb_idx   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                bit_cnt <= '0;
                idx     <= '0;
                full    <= 1'b0;
                rb_buf  <= '0;
                rb_idx  <= '0;
            end else begin
                clr_cnt <= '0;
            end
            if (cfg_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
                idx     <= last_word_bit ? '0 : idx + 1'b1;
                if (last_word_bit || last_chain_bit) begin
                    full <= 1'b0;
                end
                if (rb_idx == LAST_IDX || last_chain_bit) begin
                    rb_data  <= rb_fill;
                    rb_valid <= 1'b1;
                    rb_buf   <= '0;
                    rb_idx   <= '0;
                end else begin
                    rb_buf <= rb_fill;
                    rb_idx <= rb_idx + 1'b1;
                end
            end
            if (accept) begin
                word_buf <= bus.word_data;
                full     <= 1'b1;
                idx      <= '0;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.word_ready = word_ready;
    assign bus.cfg_reset  = cfg_reset;
    assign bus.cfg_shift  = cfg_shift;
    assign bus.cfg_in     = cfg_in;
    assign bus.rb_valid   = rb_valid;
    assign bus.rb_data    = rb_data;
endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: a cycle model of the load sequence derived from the word
// list and readback pattern, checked every negedge, plus literal expectations per scenario.
module tb_config_stream_loader;
    localparam int W   = 4;
    localparam int LEN = 10;
    localparam int CLR = 2;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    config_stream_loader_if #(.WORD_W(W)) bus ();

    config_stream_loader #(
        .WORD_W(W), .CHAIN_LEN(LEN), .CLR_CYC(CLR), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]  exp_words [0:7];
    int            gaps [0:7];
    logic [63:0]   rb_pat;
    logic [63:0]   seq;
    logic [W-1:0]  rb_log [0:7];
    logic [W-1:0]  rb_acc, m_rb_exp;
    bit            m_busy, m_done_pend, m_rb_pend;
    int            m_clr, m_shift, rb_n;
    int            n_clr, n_done, n_hs, n_stall, n_rb;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting, required event never came", name);
    endtask

    // Cycle model: what each output must be this cycle, advanced to the next cycle afterwards.
    always @(negedge clk) begin
        if (!reset) begin
            check_output("reset_ctrl_outputs",
                         {25'd0, bus.busy, bus.done, bus.word_ready, bus.cfg_reset,
                          bus.cfg_shift, bus.cfg_in, bus.rb_valid}, 32'd0);
            check_output("reset_rb_data", 32'(bus.rb_data), 32'd0);
            m_busy = 0; m_done_pend = 0; m_rb_pend = 0;
            m_clr = 0; m_shift = 0; rb_n = 0; rb_acc = '0;
            bus.cfg_out = 1'b0;
        end else begin
            check_output("busy", 32'(bus.busy), 32'(m_busy));
            check_output("cfg_reset", 32'(bus.cfg_reset), 32'(m_clr > 0));
            check_output("done", 32'(bus.done), 32'(m_done_pend));
            check_output("rb_valid", 32'(bus.rb_valid), 32'(m_rb_pend));
            if (m_rb_pend) check_output("rb_data", 32'(bus.rb_data), 32'(m_rb_exp));
            if (!m_busy || m_clr > 0 || m_done_pend) begin
                check_output("word_ready_outside_load", 32'(bus.word_ready), 32'd0);
                check_output("cfg_shift_outside_load", 32'(bus.cfg_shift), 32'd0);
            end
            if (bus.rb_valid && n_rb < 8) begin
                rb_log[n_rb] = bus.rb_data;
                n_rb++;
            end
            if (bus.cfg_reset) n_clr++;
            if (bus.done) n_done++;
            if (bus.word_valid && bus.word_ready) n_hs++;
            m_rb_pend = 0;

            if (m_done_pend) begin
                m_busy = 0;
                m_done_pend = 0;
            end else if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1; m_clr = CLR; m_shift = 0;
                    rb_n = 0; rb_acc = '0; seq = '0;
                end
            end else if (m_clr > 0) begin
                m_clr--;
            end else if (bus.cfg_shift) begin
                check_output("shift_count_in_range", 32'(m_shift < LEN), 32'd1);
                if (m_shift < LEN) begin
                    check_output("cfg_in", 32'(bus.cfg_in), 32'(exp_words[m_shift / W][m_shift % W]));
                    seq[m_shift] = bus.cfg_in;
                    bus.cfg_out = rb_pat[m_shift];
                    rb_acc[rb_n] = rb_pat[m_shift];
                    rb_n++;
                    m_shift++;
                    if (rb_n == W || m_shift == LEN) begin
                        m_rb_pend = 1;
                        m_rb_exp = rb_acc;
                        rb_acc = '0;
                        rb_n = 0;
                    end
                    if (m_shift == LEN) m_done_pend = 1;
                end
            end else if (m_shift > 0) begin
                n_stall++;
            end
        end
    end

    task automatic clear_stats();
        n_clr = 0; n_done = 0; n_hs = 0; n_stall = 0; n_rb = 0;
        for (int i = 0; i < 8; i++) rb_log[i] = '0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    // Offers exp_words[0..n-1]; gaps[i] ready cycles are skipped with word_valid low before word i.
    task automatic apply_stimulus(input int n);
        int g, k;
        for (int i = 0; i < n; i++) begin
            g = 0;
            k = 0;
            bus.word_valid = 1'b0;
            while (g < gaps[i] && k < 200) begin
                @(negedge clk);
                if (bus.word_ready) g++;
                k++;
            end
            if (g < gaps[i]) fail_timeout("gap_ready");
            if (gaps[i] > 0) begin
                @(posedge clk); #1;
            end
            bus.word_valid = 1'b1;
            bus.word_data  = exp_words[i];
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.word_ready && k < 200);
            if (!bus.word_ready) fail_timeout("word_handshake");
            @(posedge clk); #1;
            bus.word_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_busy && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (m_busy) fail_timeout("load_complete");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        exp_words[0] = a; exp_words[1] = b; exp_words[2] = c;
        for (int i = 0; i < 8; i++) gaps[i] = 0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_data = '0;
        rb_pat = '0;
        seq = '0;
        for (int i = 0; i < 8; i++) exp_words[i] = '0;
        set_words(4'h5, 4'hA, 4'h3);
        clear_stats();

        // Reset held: inputs toggle, outputs must stay quiet.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 bus.start = i[0]; bus.word_valid = ~i[0];
            @(posedge clk);
        end
        #1 bus.start = 1'b0; bus.word_valid = 1'b0;
        check_output("reset_word_ready", 32'(bus.word_ready), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Full load, no stalls.
        clear_stats();
        pulse_start();
        apply_stimulus(3);
        wait_idle();
        check_output("full_seq", 32'(seq[9:0]), 32'b1110100101);
        check_output("full_clr_cycles", n_clr, 2);
        check_output("full_handshakes", n_hs, 3);
        check_output("full_done_count", n_done, 1);
        check_output("full_shifts", m_shift, 10);
        check_output("full_stalls", n_stall, 0);
        check_output("full_rb_pulses", n_rb, 3);

        // Stall of three cycles before the last word.
        clear_stats();
        gaps[2] = 3;
        pulse_start();
        apply_stimulus(3);
        wait_idle();
        check_output("stall_seq", 32'(seq[9:0]), 32'b1110100101);
        check_output("stall_cycles", n_stall, 3);
        check_output("stall_shifts", m_shift, 10);
        check_output("stall_handshakes", n_hs, 3);

        // Readback: tail returns ones on the first four shifts.
        clear_stats();
        gaps[2] = 0;
        rb_pat = 64'hF;
        pulse_start();
        apply_stimulus(3);
        wait_idle();
        check_output("rb_pulses", n_rb, 3);
        check_output("rb_word0", 32'(rb_log[0]), 32'hF);
        check_output("rb_word1", 32'(rb_log[1]), 32'h0);
        check_output("rb_word2", 32'(rb_log[2]), 32'h0);
        rb_pat = '0;

        // Reset after five shifts aborts at once.
        clear_stats();
        pulse_start();
        apply_stimulus(2);
        begin
            int k = 0;
            while (m_shift != 5 && k < 100) begin
                @(posedge clk);
                k++;
            end
            if (m_shift != 5) fail_timeout("five_shifts");
        end
        #1 reset = 1'b0;
        #1;
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        check_output("abort_cfg_shift", 32'(bus.cfg_shift), 32'd0);
        check_output("abort_word_ready", 32'(bus.word_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_output("abort_no_done", n_done, 0);
        clear_stats();
        set_words(4'h6, 4'h9, 4'hC);
        pulse_start();
        apply_stimulus(3);
        wait_idle();
        check_output("restart_seq", 32'(seq[9:0]), 32'b0010010110);
        check_output("restart_clr_cycles", n_clr, 2);
        check_output("restart_done_count", n_done, 1);

        // start pulses during LOAD and DONE are ignored.
        clear_stats();
        set_words(4'h5, 4'hA, 4'h3);
        pulse_start();
        fork
            apply_stimulus(3);
            begin
                int k = 0;
                while (m_shift < 3 && k < 100) begin
                    @(posedge clk);
                    k++;
                end
                #1 bus.start = 1'b1;
                @(posedge clk); #1 bus.start = 1'b0;
            end
        join
        begin
            int k = 0;
            while (!m_done_pend && k < 100) begin
                @(posedge clk);
                k++;
            end
            if (!m_done_pend) fail_timeout("done_cycle");
        end
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        check_output("busy_start_done_count", n_done, 1);
        check_output("busy_start_clr_cycles", n_clr, 2);
        check_output("busy_start_handshakes", n_hs, 3);
        check_output("busy_start_idle_after", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Transmitter end of the PE configuration chain. The chain is the serial shift path through config_cell instances: config_in → config_out.
- Accepts configuration words over a valid/ready stream and clears the chain. It then serialises exactly CHAIN_LEN bits into the chain, LSB-first.
- While shifting, it captures the bits that fall out of the chain tail and returns them as readback words.
- Sits between the host/bitstream DMA and the top-level CGRA config chain.

Parameters:
- WORD_W, 32, width of input and readback words.
- CHAIN_LEN, 1024, total config bits in the attached chain (≥1).
- CLR_CYC, 2, cycles cfg_reset is held high in CLEAR (≥1).
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, begin a load sequence (sampled in IDLE only).
- busy, output, 1, high in CLEAR/LOAD/DONE.
- done, output, 1, one-cycle pulse when the load completes.
- word_valid, input, 1, config word available.
- word_data, input, WORD_W, config word, bit 0 shifted first.
- word_ready, output, 1, loader accepts word this cycle.
- cfg_reset, output, 1, drives config_reset of the chain.
- cfg_shift, output, 1, shift enable (gates config_clk); exactly one chain bit per high cycle.
- cfg_in, output, 1, bit presented to chain config_in; valid when cfg_shift=1.
- cfg_out, input, 1, chain tail config_out; sampled when cfg_shift=1.
- rb_valid, output, 1, one-cycle pulse: rb_data holds a readback word.
- rb_data, output, WORD_W, captured tail bits, first-captured in bit 0.

Behaviour:
- Reset (reset=0, async): state=IDLE. busy, done, word_ready, cfg_reset, cfg_shift, cfg_in, rb_valid = 0; rb_data=0. Bit counter, word buffer and readback buffer are cleared.
- FSM: IDLE → CLEAR on start=1. CLEAR holds cfg_reset=1 for exactly CLR_CYC cycles, then → LOAD. LOAD → DONE in the cycle after the CHAIN_LEN-th shift. DONE lasts one cycle with done=1, then → IDLE.
- start is ignored outside IDLE. busy=1 in every non-IDLE state.
- Word buffer: holds one word plus bit index idx (0..WORD_W-1) and a full flag.
  - Handshake: accept when word_valid && word_ready.
  - word_ready=1 in LOAD when the buffer is empty, or when it is full and the last buffered bit (idx=WORD_W-1) is shifting this cycle. This gives zero-bubble back-to-back words.
  - word_ready=0 in all other states.
  - Bits shifted ≤ CHAIN_LEN ⇒ words accepted = ceil(CHAIN_LEN/WORD_W).
- Shifting:
  - cfg_shift = (state==LOAD && buffer full); cfg_in = buffer[idx]. Both are driven from registers only; there is no combinational path from word_* inputs.
  - Each cfg_shift cycle increments the bit counter and idx. The buffer empties when idx wraps, or when the counter reaches CHAIN_LEN.
  - In the final word, bits beyond CHAIN_LEN are discarded and never shifted.
- Stall: with the buffer empty in LOAD, cfg_shift=0 and the counter holds. A stall has no effect on bit ordering or count.
- Readback:
  - On each cfg_shift cycle, cfg_out is written into the readback buffer at position rb_idx.
  - When WORD_W bits are collected, or the CHAIN_LEN-th bit is captured, the buffer is transferred to rb_data. rb_valid pulses high for one cycle, in the cycle after that shift. Unfilled upper bits are 0.
  - rb has no backpressure; the consumer must accept.
- rb_data holds its last value until the next pulse; rb_idx restarts at 0 after each pulse.
- Reset mid-operation aborts immediately: a partial word is dropped and no done is issued. The next start restarts from CLEAR, bit 0.

Test Plan:
- Reset check: hold reset=0, toggle start/word_valid → all outputs 0, busy stays 0, word_ready=0.
- Full load, with WORD_W=4, CHAIN_LEN=10, CLR_CYC=2. Send start, then words 0x5, 0xA, 0x3 with word_valid held high.
  - cfg_reset high for exactly 2 cycles.
  - Then 10 consecutive cfg_shift cycles with cfg_in = 1,0,1,0,0,1,0,1,1,1.
  - 3 handshakes in total; done pulses 1 cycle after the last shift; busy falls the following cycle.
- Stall: same stimulus, but word_valid=0 for 3 cycles between 0xA and 0x3 → cfg_shift=0 for those 3 cycles. Same 10-bit sequence; total shifts=10.
- Readback: bench drives cfg_out=1 on shifts 1-4 and 0 after → rb_valid pulses carrying 0xF, then 0x0, then 0x0 (2-bit partial, upper bits 0). Each pulse is 1 cycle after shifts 4, 8 and 10.
- Reset mid-load: assert reset after 5 shifts → same cycle busy=0, cfg_shift=0, word_ready=0, no done. A new start re-enters CLEAR and shifts bit 0 of the next word first.
- Start while busy: pulse start during LOAD and during DONE → no restart, no extra CLEAR; exactly one done for the sequence.
